fpu_div_arbiter: RTL and testbench

FPU_DIV_ARBITER -- requirements
Module: fpu_div_arbiter

---
 rtl/fpu_pkg.sv | 14 +
 rtl/fpu_rr_pick.sv | 32 +++
 rtl/fpu_div_arbiter.sv | 97 +++++++++
 tb/tb_fpu_div_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU divider arbiter.
// Holds the operand width and the arbiter state encoding.
package fpu_pkg;

  localparam int FPU_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DIV,
    RESPOND
  } div_st_e;

endpackage

// File: rtl/fpu_rr_pick.sv
// Round-robin picker: first eligible requester at or after ptr.
// Purely combinational; wraps from NREQ-1 back to 0.
module fpu_rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] eligible,
  input  logic [IW-1:0]   ptr,
  output logic            found,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx
);

  int j;

  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && eligible[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/fpu_div_arbiter.sv
// Shares one external divider between NREQ requesters.
// One operation in flight; round-robin grant in IDLE.
module fpu_div_arbiter
  import fpu_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*FPU_W-1:0] req_din1,
  input  logic [NREQ*FPU_W-1:0] req_din2,
  output logic [NREQ-1:0]       req_accept,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [FPU_W-1:0]      rsp_result,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [FPU_W-1:0]      div_din1,
  output logic [FPU_W-1:0]      div_din2,
  output logic                  div_valid,
  input  logic [FPU_W-1:0]      div_result,
  input  logic                  div_ready,
  output logic                  busy
);

  localparam int IW = $clog2(NREQ);

  div_st_e         state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   win_idx;
  logic [NREQ-1:0] win_oh;
  logic [NREQ-1:0] eligible;
  logic            found;

  assign eligible = req_valid & ~rsp_valid;

  fpu_rr_pick #(
    .NREQ(NREQ),
    .IW  (IW)
  ) u_pick (
    .eligible(eligible),
    .ptr     (rr_ptr),
    .found   (found),
    .grant   (win_oh),
    .idx     (win_idx)
  );

  // Accept is the grant itself, so it lines up with the capture edge.
  assign req_accept = (state == IDLE && !reset) ? win_oh : '0;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      rsp_valid  <= '0;
      rsp_result <= '0;
      div_valid  <= 1'b0;
      div_din1   <= '0;
      div_din2   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            div_din1  <= req_din1[int'(win_idx)*FPU_W +: FPU_W];
            div_din2  <= req_din2[int'(win_idx)*FPU_W +: FPU_W];
            owner     <= win_idx;
            div_valid <= 1'b1;
            state     <= ISSUE;
            if (int'(win_idx) == NREQ - 1) rr_ptr <= '0;
            else rr_ptr <= win_idx + IW'(1);
          end
        end
        ISSUE: begin
          div_valid <= 1'b0;
          state     <= WAIT_DIV;
        end
        WAIT_DIV: begin
          if (div_ready) begin
            rsp_result <= div_result;
            rsp_valid  <= NREQ'(1) << owner;
            state      <= RESPOND;
          end
        end
        RESPOND: begin
          if (rsp_ready[owner]) begin
            rsp_valid <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_div_arbiter.sv
// Bench for fpu_div_arbiter: transaction model plus directed cases.
// Includes a latency-programmable divider model.
module tb_fpu_div_arbiter;
  import fpu_pkg::*;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N*32-1:0] din1 = '0;
  logic [N*32-1:0] din2 = '0;
  logic [N-1:0]  req_accept;
  logic [N-1:0]  rsp_valid;
  logic [31:0]   rsp_result;
  logic [N-1:0]  rsp_ready;
  logic [N-1:0]  rdy_mask = '1;
  logic [31:0]   div_din1, div_din2;
  logic          div_valid;
  logic [31:0]   div_result;
  logic          div_ready;
  logic          dr_m = 1'b0;
  logic          stray = 1'b0;
  logic          busy;

  always #5 clk = ~clk;

  assign rsp_ready = rdy_mask;
  assign div_ready = dr_m | stray;

  fpu_div_arbiter #(.NREQ(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_din1  (din1),
    .req_din2  (din2),
    .req_accept(req_accept),
    .rsp_valid (rsp_valid),
    .rsp_result(rsp_result),
    .rsp_ready (rsp_ready),
    .div_din1  (div_din1),
    .div_din2  (div_din2),
    .div_valid (div_valid),
    .div_result(div_result),
    .div_ready (div_ready),
    .busy      (busy)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out @%0t", nm, $time);
  endtask

  function automatic logic [31:0] fdiv(input logic [31:0] a,
                                       input logic [31:0] b);
    if (a == 32'h40800000 && b == 32'h40000000) return 32'h40000000;
    if (a == 32'h3F800000 && b == 32'h00000000) return 32'h7F800000;
    if (a == 32'h00000000 && b == 32'h00000000) return 32'hFFC00000;
    return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A0000;
  endfunction

  // Divider model, cleared by the same reset as the arbiter.
  int          dlat = 1;
  logic        dpend = 1'b0;
  int          dcnt = 0;
  logic [31:0] dres = '0;

  assign div_result = dres;

  always @(posedge clk) begin
    if (reset) begin
      dpend <= 1'b0;
      dr_m  <= 1'b0;
    end else begin
      dr_m <= 1'b0;
      if (div_valid) begin
        dpend <= 1'b1;
        dcnt  <= dlat - 1;
        dres  <= fdiv(div_din1, div_din2);
      end else if (dpend) begin
        if (dcnt == 0) begin
          dr_m  <= 1'b1;
          dpend <= 1'b0;
        end else begin
          dcnt <= dcnt - 1;
        end
      end
    end
  end

  // Transaction-level model of the arbiter.
  int          mptr = 0;
  bit          open = 0, issued = 0, have = 0, acc_prev = 0;
  int          owner = 0;
  logic [31:0] ld1 = '0, ld2 = '0, mres = '0;
  int          gq[$];
  int          rown[$];
  logic [31:0] rq[$];
  int          nissue = 0;
  int          w, di;
  logic [N-1:0] exp_acc, exp_rv;

  always @(negedge clk) begin
    if (reset) begin
      chk("accept_in_reset", 32'(req_accept), 32'h0);
      mptr = 0; open = 0; issued = 0; have = 0; acc_prev = 0;
      ld1 = '0; ld2 = '0; mres = '0;
    end else begin
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && req_valid[(mptr + k) % N]) w = (mptr + k) % N;
      exp_acc = (!open && w >= 0) ? N'(1) << w : '0;
      exp_rv  = have ? N'(1) << owner : '0;
      chk("req_accept", 32'(req_accept), 32'(exp_acc));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      chk("rsp_result", rsp_result, mres);
      chk("busy", 32'(busy), 32'(open));
      chk("div_valid", 32'(div_valid), 32'(acc_prev));
      chk("div_din1", div_din1, ld1);
      chk("div_din2", div_din2, ld2);
      if (div_valid) nissue++;
      if (req_accept != 0) begin
        di = 0;
        for (int k = 0; k < N; k++) if (req_accept[k]) di = k;
        gq.push_back(di);
      end
      if (have && rdy_mask[owner]) begin
        rq.push_back(rsp_result);
        rown.push_back(owner);
        open = 0; issued = 0; have = 0;
      end else if (issued && !have && div_ready) begin
        have = 1;
        mres = div_result;
      end
      if (acc_prev) issued = 1;
      acc_prev = (exp_acc != 0);
      if (exp_acc != 0) begin
        open  = 1;
        owner = w;
        ld1   = din1[w*32 +: 32];
        ld2   = din2[w*32 +: 32];
        mptr  = (w + 1) % N;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_grants(input int n, input string nm);
    int t = 0;
    while (gq.size() < n && t < 200) begin
      tick();
      t++;
    end
    if (gq.size() < n) timeout(nm);
  endtask

  task automatic wait_rsps(input int n, input string nm);
    int t = 0;
    while (rq.size() < n && t < 400) begin
      tick();
      t++;
    end
    if (rq.size() < n) timeout(nm);
  endtask

  task automatic set_op(input int i, input logic [31:0] a,
                        input logic [31:0] b);
    din1[i*32 +: 32] = a;
    din2[i*32 +: 32] = b;
  endtask

  int gb, rb, ib, t;
  logic [31:0] hold;
  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    do_reset();
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_rsp_result", rsp_result, 32'h0);

    // Single request
    set_op(0, 32'h40800000, 32'h40000000);
    req_valid = 4'b0001;
    wait_grants(1, "single_grant");
    req_valid = '0;
    wait_rsps(1, "single_rsp");
    chk("single_result", rq[0], 32'h40000000);
    chk("single_owner", 32'(rown[0]), 32'h0);
    chk("single_accepts", 32'(gq.size()), 32'h1);
    chk("single_issues", 32'(nissue), 32'h1);

    // All requesters held valid
    do_reset();
    dlat = 2;
    for (int i = 0; i < N; i++)
      set_op(i, 32'h3F800000 + i, 32'h40000000 + 16 * i);
    gb = gq.size();
    rb = rq.size();
    ib = nissue;
    req_valid = '1;
    wait_grants(gb + 5, "rr_grants");
    req_valid = '0;
    wait_rsps(rb + 5, "rr_rsps");
    for (int k = 0; k < 5; k++)
      if (gq.size() > gb + k) chk("rr_order", 32'(gq[gb + k]), 32'(exp_order[k]));
    chk("rr_issues", 32'(nissue - ib), 32'd5);

    // Pointer at 2, requesters 0 and 1 valid
    do_reset();
    dlat = 1;
    set_op(0, 32'h11111111, 32'h22222222);
    set_op(1, 32'h33333333, 32'h44444444);
    gb = gq.size();
    rb = rq.size();
    req_valid = 4'b0010;
    wait_grants(gb + 1, "ptr_setup");
    req_valid = '0;
    wait_rsps(rb + 1, "ptr_setup_rsp");
    req_valid = 4'b0011;
    wait_grants(gb + 2, "ptr_g0");
    req_valid = '0;
    wait_rsps(rb + 2, "ptr_r0");
    req_valid = 4'b0011;
    wait_grants(gb + 3, "ptr_g1");
    req_valid = '0;
    wait_rsps(rb + 3, "ptr_r1");
    if (gq.size() >= gb + 3) begin
      chk("ptr_wrap_winner", 32'(gq[gb + 1]), 32'h0);
      chk("ptr_next_winner", 32'(gq[gb + 2]), 32'h1);
    end

    // Response withheld for 20 cycles
    dlat = 3;
    rdy_mask = '0;
    set_op(2, 32'h40400000, 32'h3F000000);
    gb = gq.size();
    rb = rq.size();
    ib = nissue;
    req_valid = 4'b0100;
    wait_grants(gb + 1, "hold_grant");
    t = 0;
    while (!rsp_valid[2] && t < 50) begin
      tick();
      t++;
    end
    if (!rsp_valid[2]) timeout("hold_rsp_rise");
    hold = rsp_result;
    chk("hold_result_val", hold, fdiv(32'h40400000, 32'h3F000000));
    repeat (20) begin
      tick();
      chk("hold_valid", 32'(rsp_valid), 32'h4);
      chk("hold_result", rsp_result, hold);
    end
    chk("hold_accepts", 32'(gq.size() - gb), 32'h1);
    chk("hold_issues", 32'(nissue - ib), 32'h1);
    req_valid = '0;
    rdy_mask = '1;
    wait_rsps(rb + 1, "hold_release");

    // Special encodings pass through; stray div_ready in IDLE
    tick();
    stray = 1'b1;
    tick();
    stray = 1'b0;
    tick();
    chk("stray_ignored", 32'(rsp_valid), 32'h0);
    rb = rq.size();
    set_op(3, 32'h3F800000, 32'h00000000);
    req_valid = 4'b1000;
    wait_rsps(rb + 1, "inf_rsp");
    req_valid = '0;
    set_op(1, 32'h00000000, 32'h00000000);
    tick();
    req_valid = 4'b0010;
    wait_rsps(rb + 2, "nan_rsp");
    req_valid = '0;
    if (rq.size() >= rb + 2) begin
      chk("inf_result", rq[rb], 32'h7F800000);
      chk("nan_result", rq[rb + 1], 32'hFFC00000);
    end

    // Reset while waiting on the divider
    dlat = 8;
    tick();
    set_op(0, 32'h12345678, 32'h0BADF00D);
    gb = gq.size();
    rb = rq.size();
    req_valid = 4'b0001;
    wait_grants(gb + 1, "abort_grant");
    req_valid = '0;
    tick();
    chk("abort_in_wait", 32'(busy), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_div_valid", 32'(div_valid), 32'h0);
    chk("abort_div_din1", div_din1, 32'h0);
    chk("abort_div_din2", div_din2, 32'h0);
    chk("abort_rsp_result", rsp_result, 32'h0);
    repeat (15) tick();
    chk("abort_no_rsp", 32'(rq.size() - rb), 32'h0);
    dlat = 2;
    set_op(3, 32'h40800000, 32'h40000000);
    req_valid = 4'b1000;
    wait_rsps(rb + 1, "after_abort");
    req_valid = '0;
    if (rq.size() > rb) begin
      chk("after_abort_result", rq[rb], 32'h40000000);
      chk("after_abort_owner", 32'(rown[rb]), 32'h3);
    end
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
